// File: rtl/ex_pkg.sv
// rtl/ex_pkg.sv - shared EX-stage constants and multiplier sequencer state encoding.
package ex_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [3:0] ALU_OP_MUL = 4'b1011;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_RUN  = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/ex_mul_seq_if.sv
// rtl/ex_mul_seq_if.sv - EX-stage multiply request/response bundle.
interface ex_mul_seq_if import ex_pkg::*; #(
  parameter int XLEN = XLEN_DEFAULT
);

  logic            EX_mul_start;
  logic [XLEN-1:0] EX_a;
  logic [XLEN-1:0] EX_b;
  logic            EX_flush;
  logic            EX_mul_stall;
  logic            EX_mul_busy;
  logic            EX_mul_done;
  logic [XLEN-1:0] EX_mul_result;

  modport master (
    output EX_mul_start, EX_a, EX_b, EX_flush,
    input  EX_mul_stall, EX_mul_busy, EX_mul_done, EX_mul_result
  );

  modport slave (
    input  EX_mul_start, EX_a, EX_b, EX_flush,
    output EX_mul_stall, EX_mul_busy, EX_mul_done, EX_mul_result
  );

endinterface

// File: rtl/ex_mul_seq.sv
// rtl/ex_mul_seq.sv - iterative radix-2 shift-add multiplier for the EX stage.
module ex_mul_seq import ex_pkg::*; #(
  parameter int XLEN       = XLEN_DEFAULT,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  ex_mul_seq_if.slave  bus
);

  localparam int              CW       = $clog2(XLEN) + 1;
  localparam logic [CW-1:0]   LAST_CNT = CW'(XLEN - 1);

  mul_state_e      r_state;
  mul_state_e      w_state_next;
  logic [XLEN-1:0] r_mcand;
  logic [XLEN-1:0] r_mplier;
  logic [XLEN-1:0] r_acc;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_result;

  logic            w_accept;
  logic            w_last;
  logic [XLEN-1:0] w_acc_next;
  logic [XLEN-1:0] w_mplier_sh;

  assign w_accept    = (r_state == MUL_IDLE) && bus.EX_mul_start && !bus.EX_flush;
  assign w_acc_next  = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign w_mplier_sh = r_mplier >> 1;
  // Early exit once no set multiplier bits remain beyond the current one.
  assign w_last      = (r_cnt == LAST_CNT) || (EARLY_EXIT && (w_mplier_sh == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= MUL_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (bus.EX_flush) begin
      w_state_next = MUL_IDLE;
    end else begin
      case (r_state)
        MUL_IDLE: if (bus.EX_mul_start) w_state_next = MUL_RUN;
        MUL_RUN:  if (w_last) w_state_next = MUL_DONE;
        MUL_DONE: w_state_next = MUL_IDLE;
        default:  w_state_next = MUL_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_mcand  <= bus.EX_a;
      r_mplier <= bus.EX_b;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if ((r_state == MUL_RUN) && !bus.EX_flush) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= w_mplier_sh;
      r_cnt    <= r_cnt + CW'(1);
      // Result register only moves on a completed operation, so aborts leave it intact.
      if (w_last) r_result <= w_acc_next;
    end
  end

  assign bus.EX_mul_stall  = w_accept || (r_state == MUL_RUN);
  assign bus.EX_mul_busy   = (r_state != MUL_IDLE);
  assign bus.EX_mul_done   = (r_state == MUL_DONE);
  assign bus.EX_mul_result = r_result;

endmodule

// File: tb/tb_ex_mul_seq.sv
// tb/tb_ex_mul_seq.sv - scoreboard bench for ex_mul_seq (early-exit and fixed-latency builds).
module tb_ex_mul_seq;

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;
  exp_t q0[$];
  exp_t q1[$];
  logic [31:0] last0;

  ex_mul_seq_if #(.XLEN(32)) m0();
  ex_mul_seq_if #(.XLEN(32)) m1();

  ex_mul_seq #(.XLEN(32), .EARLY_EXIT(1'b1)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(m0));
  ex_mul_seq #(.XLEN(32), .EARLY_EXIT(1'b0)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(m1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic o_stall(input int sel);
    return (sel == 0) ? m0.EX_mul_stall : m1.EX_mul_stall;
  endfunction
  function automatic logic o_busy(input int sel);
    return (sel == 0) ? m0.EX_mul_busy : m1.EX_mul_busy;
  endfunction
  function automatic logic o_done(input int sel);
    return (sel == 0) ? m0.EX_mul_done : m1.EX_mul_done;
  endfunction
  function automatic int qsize(input int sel);
    return (sel == 0) ? q0.size() : q1.size();
  endfunction

  function automatic int lat(input logic [31:0] b, input bit early);
    int n;
    if (!early) return 32;
    n = 1;
    for (int i = 0; i < 32; i++) if (b[i]) n = i + 1;
    return n;
  endfunction

  task automatic drive(input int sel, input logic s, input logic [31:0] a,
                       input logic [31:0] b, input logic f);
    if (sel == 0) begin
      m0.EX_mul_start = s; m0.EX_a = a; m0.EX_b = b; m0.EX_flush = f;
    end else begin
      m1.EX_mul_start = s; m1.EX_a = a; m1.EX_b = b; m1.EX_flush = f;
    end
  endtask

  task automatic push(input int sel, input logic [31:0] r, input int c);
    exp_t e;
    e.res = r;
    e.cyc = c;
    if (sel == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  task automatic wait_empty(input int sel);
    int k;
    k = 0;
    while (qsize(sel) != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (qsize(sel) != 0) begin
      check("done_timeout", 64'(qsize(sel)), 0);
      if (sel == 0) q0.delete(); else q1.delete();
    end
  endtask

  task automatic do_mul(input int sel, input logic [31:0] a, input logic [31:0] b, input bit full);
    int n;
    int c0;
    logic [31:0] p;
    n = lat(b, sel == 0);
    p = a * b;
    @(negedge clk);
    drive(sel, 1'b1, a, b, 1'b0);
    #1;
    c0 = cyc;
    push(sel, p, c0 + n + 1);
    if (full) begin
      check("stall_t0", o_stall(sel), 1);
      check("busy_t0", o_busy(sel), 0);
    end
    @(negedge clk);
    drive(sel, 1'b0, $urandom, $urandom, 1'b0);
    if (full) begin
      for (int i = 1; i <= n; i++) begin
        if (i > 1) @(negedge clk);
        #1;
        check("stall_run", o_stall(sel), 1);
        check("busy_run", o_busy(sel), 1);
        check("done_run", o_done(sel), 0);
      end
      @(negedge clk);
      #1;
      check("stall_done", o_stall(sel), 0);
      check("busy_done", o_busy(sel), 1);
      @(negedge clk);
      #1;
      check("busy_after", o_busy(sel), 0);
    end
    wait_empty(sel);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && m0.EX_mul_done) begin
      if (q0.size() == 0) begin
        check("spurious_done0", m0.EX_mul_done, 0);
      end else begin
        e = q0.pop_front();
        check("result0", m0.EX_mul_result, e.res);
        check("done_cyc0", 64'(cyc), 64'(e.cyc));
        last0 = e.res;
      end
    end
    if (rst_n && m1.EX_mul_done) begin
      if (q1.size() == 0) begin
        check("spurious_done1", m1.EX_mul_done, 0);
      end else begin
        e = q1.pop_front();
        check("result1", m1.EX_mul_result, e.res);
        check("done_cyc1", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    last0  = '0;
    rst_n  = 1'b0;
    drive(0, 1'b0, '0, '0, 1'b0);
    drive(1, 1'b0, '0, '0, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    check("rst_stall", m0.EX_mul_stall, 0);
    check("rst_busy", m0.EX_mul_busy, 0);
    check("rst_done", m0.EX_mul_done, 0);
    check("rst_result", m0.EX_mul_result, 0);
    @(negedge clk);
    rst_n = 1'b1;

    do_mul(0, 32'd6, 32'd7, 1'b1);
    do_mul(0, 32'h1234, 32'd0, 1'b1);
    do_mul(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    for (int i = 0; i < 6; i++) begin
      do_mul(0, $urandom, $urandom >> $urandom_range(0, 31), 1'b0);
    end

    // Flush during RUN: no done, result unchanged, block back in IDLE.
    @(negedge clk);
    drive(0, 1'b1, 32'd5, 32'h8000_0000, 1'b0);
    @(negedge clk);
    drive(0, 1'b0, '0, '0, 1'b0);
    repeat (3) @(negedge clk);
    @(negedge clk);
    drive(0, 1'b0, '0, '0, 1'b1);
    @(negedge clk);
    drive(0, 1'b0, '0, '0, 1'b0);
    #1;
    check("flush_busy", m0.EX_mul_busy, 0);
    check("flush_result", m0.EX_mul_result, last0);
    do_mul(0, 32'd3, 32'd4, 1'b0);

    // Start and flush together in IDLE.
    @(negedge clk);
    drive(0, 1'b1, 32'd7, 32'd7, 1'b1);
    #1;
    check("sf_stall", m0.EX_mul_stall, 0);
    @(negedge clk);
    drive(0, 1'b0, '0, '0, 1'b0);
    #1;
    check("sf_busy", m0.EX_mul_busy, 0);

    // Start held during RUN with other operands is ignored.
    @(negedge clk);
    drive(0, 1'b1, 32'd6, 32'd7, 1'b0);
    #1;
    push(0, 32'd42, cyc + 4);
    @(negedge clk);
    drive(0, 1'b1, 32'd9, 32'd9, 1'b0);
    @(negedge clk);
    @(negedge clk);
    drive(0, 1'b0, '0, '0, 1'b0);
    wait_empty(0);
    @(negedge clk);
    #1;
    check("ign_busy", m0.EX_mul_busy, 0);

    // Asynchronous reset between edges mid-RUN.
    @(negedge clk);
    drive(0, 1'b1, 32'd5, 32'h8000_0000, 1'b0);
    @(negedge clk);
    drive(0, 1'b0, '0, '0, 1'b0);
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", m0.EX_mul_busy, 0);
    check("arst_stall", m0.EX_mul_stall, 0);
    check("arst_done", m0.EX_mul_done, 0);
    check("arst_result", m0.EX_mul_result, 0);
    last0 = '0;
    @(negedge clk);
    rst_n = 1'b1;
    do_mul(0, 32'd2, 32'd3, 1'b1);

    // Fixed-latency build.
    do_mul(1, 32'hDEAD_BEEF, 32'd1, 1'b1);
    do_mul(1, $urandom, $urandom, 1'b0);
    do_mul(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
